// File: rtl/ft2232h_fifo_arbiter_pkg.sv
// Shared definitions for the FT2232H 245 synchronous-FIFO arbiter:
// arbiter state encodings and the grant-direction tags.
package ft2232h_fifo_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RX_OE  = 3'd1,
    RX     = 3'd2,
    TURN   = 3'd3,
    TX_DRV = 3'd4,
    TX     = 3'd5
  } state_t;

  typedef enum logic {
    GRANT_RX = 1'b0,
    GRANT_TX = 1'b1
  } grant_t;

endpackage

// File: rtl/ft2232h_tx_hold.sv
// One-byte TX holding register between the user stream and the FT bus.
// A byte leaves only on an edge where WR# is low and TXE# is low.
module ft2232h_tx_hold (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_active,
  input  logic       burst_ok,
  input  logic       txe_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic [7:0] hold_data,
  output logic       hold_valid,
  output logic       hold_valid_next,
  output logic       tx_ready,
  output logic       send,
  output logic       consumed
);

  logic [7:0] hold_data_reg;
  logic       hold_valid_reg;
  logic       load;

  assign send            = tx_active & hold_valid_reg & burst_ok;
  assign consumed        = send & !txe_n;
  assign tx_ready        = !hold_valid_reg | consumed;
  assign load            = tx_valid & tx_ready;
  // A reload on the consuming edge keeps the register full for back-to-back bytes.
  assign hold_valid_next = load | (hold_valid_reg & !consumed);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_valid_reg <= 1'b0;
      hold_data_reg  <= 8'h00;
    end else begin
      hold_valid_reg <= hold_valid_next;
      if (load) begin
        hold_data_reg <= tx_data;
      end
    end
  end

  assign hold_data  = hold_data_reg;
  assign hold_valid = hold_valid_reg;

endmodule

// File: rtl/ft2232h_fifo_arbiter.sv
// FT2232H 245 synchronous-FIFO bus controller: round-robin arbitration of
// the shared data bus between host->FPGA reads and FPGA->host writes.
module ft2232h_fifo_arbiter
  import ft2232h_fifo_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxf_n,
  input  logic       txe_n,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       oe_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic [7:0] rx_data,
  output logic       rx_wr,
  input  logic       rx_afull,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_BURST);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [BW-1:0] BURST_ONE  = BW'(1);

  state_t          state_reg, state_next;
  grant_t          last_grant_reg, last_grant_next;
  logic [BW-1:0]   burst_cnt_reg, burst_cnt_next;
  logic            oe_n_reg, oe_n_next;
  logic            rd_n_reg, rd_n_next;
  logic            data_oe_reg, data_oe_next;
  logic            rx_wr_reg, rx_wr_next;
  logic [7:0]      rx_data_reg, rx_data_next;

  logic [7:0] hold_data;
  logic       hold_valid, hold_valid_next, send, consumed;
  logic       rx_req, tx_req, grant_rx, grant_tx, rx_xfer;

  ft2232h_tx_hold u_tx_hold (
    .clk            (clk),
    .reset          (reset),
    .tx_active      (state_reg == TX),
    .burst_ok       (burst_cnt_reg < BURST_MAX),
    .txe_n          (txe_n),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .hold_data      (hold_data),
    .hold_valid     (hold_valid),
    .hold_valid_next(hold_valid_next),
    .tx_ready       (tx_ready),
    .send           (send),
    .consumed       (consumed)
  );

  assign rx_req   = !rxf_n & !rx_afull;
  assign tx_req   = !txe_n & (hold_valid | tx_valid);
  // On a tie the direction not served last wins.
  assign grant_rx = rx_req & (!tx_req | (last_grant_reg == GRANT_TX));
  assign grant_tx = tx_req & !grant_rx;
  assign rx_xfer  = (state_reg == RX) & !rd_n_reg & !rxf_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= GRANT_TX;
      burst_cnt_reg  <= '0;
      oe_n_reg       <= 1'b1;
      rd_n_reg       <= 1'b1;
      data_oe_reg    <= 1'b0;
      rx_wr_reg      <= 1'b0;
      rx_data_reg    <= 8'h00;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      burst_cnt_reg  <= burst_cnt_next;
      oe_n_reg       <= oe_n_next;
      rd_n_reg       <= rd_n_next;
      data_oe_reg    <= data_oe_next;
      rx_wr_reg      <= rx_wr_next;
      rx_data_reg    <= rx_data_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    burst_cnt_next  = burst_cnt_reg;
    oe_n_next       = oe_n_reg;
    rd_n_next       = rd_n_reg;
    data_oe_next    = data_oe_reg;
    rx_wr_next      = 1'b0;
    rx_data_next    = rx_data_reg;
    case (state_reg)
      IDLE: begin
        if (grant_rx) begin
          state_next      = RX_OE;
          oe_n_next       = 1'b0;
          last_grant_next = GRANT_RX;
          burst_cnt_next  = '0;
        end else if (grant_tx) begin
          state_next      = TX_DRV;
          data_oe_next    = 1'b1;
          last_grant_next = GRANT_TX;
          burst_cnt_next  = '0;
        end
      end
      RX_OE: begin
        rd_n_next  = 1'b0;
        state_next = RX;
      end
      RX: begin
        if (rx_xfer) begin
          rx_data_next   = data_in;
          rx_wr_next     = 1'b1;
          burst_cnt_next = burst_cnt_reg + BURST_ONE;
        end
        if (rxf_n | rx_afull | (rx_xfer & (burst_cnt_reg == BURST_LAST))) begin
          rd_n_next  = 1'b1;
          oe_n_next  = 1'b1;
          state_next = TURN;
        end
      end
      TURN:   state_next = IDLE;
      TX_DRV: state_next = TX;
      TX: begin
        if (consumed) begin
          burst_cnt_next = burst_cnt_reg + BURST_ONE;
        end
        // Leave as soon as nothing is left to send or the burst budget is spent.
        if (txe_n | (burst_cnt_next == BURST_MAX) | !hold_valid_next) begin
          data_oe_next = 1'b0;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    wr_n     = !send;
    oe_n     = oe_n_reg;
    rd_n     = rd_n_reg;
    data_oe  = data_oe_reg;
    data_out = hold_data;
    rx_wr    = rx_wr_reg;
    rx_data  = rx_data_reg;
  end

endmodule
